led_pio_sequencer: RTL and testbench
====================================

Name: led_pio_sequencer

Overview:
Autonomous controller for the 8-bit LED PIO slave. Acts as an Avalon-MM master on the PIO's s1 port and issues single-cycle register writes that animate the LEDs: static, blink, rotate or binary count, at a programmable rate. Software configures it through its own zero-wait Avalon-MM slave. The sequencer then owns the PIO data register with no further CPU traffic.

Parameters:
LED_WIDTH, 8, width of PIO data register and pattern/shadow registers
DIV_WIDTH, 24, width of prescaler divider register and counter
DEFAULT_DIV, 24'd5_000_000, divider value loaded at reset

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
s_address  in  2  config register select
s_chipselect  in  1  config slave select
s_write_n  in  1  config write strobe, active low
s_writedata  in  32  config write data
s_readdata  out  32  config read data, combinational, zero wait states
m_address  out  2  PIO address, always 0
m_chipselect  out  1  PIO select
m_write_n  out  1  PIO write strobe, active low
m_writedata  out  32  {zeros, shadow[LED_WIDTH-1:0]}
leds_shadow  out  LED_WIDTH  copy of the last value written to the PIO

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high.
- Config registers (write when s_chipselect & ~s_write_n):
  - addr0 CTRL: [0] enable, [2:1] mode (0 static, 1 blink, 2 rotate-left, 3 count).
  - addr1 PATTERN: [LED_WIDTH-1:0].
  - addr2 DIVIDER: [DIV_WIDTH-1:0].
  - addr3 STATUS: read-only, [15:0] write_count, [17:16] state. Writes are ignored.
  - Unused read bits are 0. Reads have no side effects.
- Reset values:
  - CTRL=0, PATTERN=0, DIVIDER=DEFAULT_DIV, shadow=0, prescaler=0, write_count=0, state=IDLE.
  - m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.
- Effective divider D = max(DIVIDER,1).
- FSM:
  - IDLE: bus idle. If enable=1: shadow<=PATTERN, prescaler<=0, go to WRITE.
  - WRITE: exactly one cycle. m_chipselect=1, m_write_n=0, m_writedata={0,shadow}. Bus outputs decode from state only. write_count increments and wraps at 16 bits. Next state is RUN if enable=1, else IDLE.
  - RUN:
    - If enable=0, go to IDLE.
    - mode 0: no ticks; stay in RUN.
    - Otherwise prescaler increments. When prescaler==D-1: prescaler<=0, shadow<=next(shadow), go to WRITE.
- next():
  - blink: (shadow==PATTERN) ? 0 : PATTERN
  - rotate: {shadow[LED_WIDTH-2:0], shadow[LED_WIDTH-1]}
  - count: shadow+1 mod 2^LED_WIDTH
- Timing:
  - In RUN, consecutive PIO writes are spaced D+1 cycles apart.
  - A CTRL enable write sampled at edge E puts the bus write in cycle E+1; the PIO captures it at edge E+2.
- PATTERN write while enable=1 and state is RUN:
  - shadow<=new PATTERN, prescaler<=0, go to WRITE.
  - Takes priority over a tick in the same cycle.
- PATTERN write while in WRITE: latched into PATTERN and applied by a restart in the following RUN cycle. The current write completes unchanged.
- Mode or DIVIDER change while running: takes effect at the next tick. Prescaler is not cleared. If the new D-1 is below the current prescaler, the prescaler keeps counting and wraps at 2^DIV_WIDTH.
- Disable (enable cleared): an in-progress WRITE cycle completes. No further writes are issued, the LEDs keep their last value, and shadow and write_count hold.
- Re-enable: restarts from PATTERN.
- reset asserted mid-operation: bus outputs return to idle immediately (asynchronously) and all state clears. No partial write is possible, since writes are one cycle.

Test Plan:
- Reset -> all bus outputs idle, leds_shadow=0. Reading addr2 returns DEFAULT_DIV; reading addr3 returns 0.
- PATTERN=0xA5, DIVIDER=3, CTRL=0x01 (static) -> exactly one PIO write of 0x000000A5 one cycle after the CTRL write. No writes in the next 100 cycles. STATUS[15:0]=1.
- PATTERN=0x81, DIVIDER=3, CTRL=0x05 (rotate) -> writes 0x81, 0x03, 0x06, 0x0C, spaced 4 cycles apart.
- PATTERN=0xFE, DIVIDER=0, CTRL=0x07 (count) -> writes 0xFE, 0xFF, 0x00, 0x01, spaced 2 cycles apart (D=1), wrapping correctly.
- Blink, PATTERN=0x0F, DIVIDER=5; write PATTERN=0x3C in the same cycle as a tick -> the next bus write is 0x3C and the following one 0x00, after 6 cycles.
- Rotate running; clear enable -> no writes after the current one and STATUS stable. Then, running again, pulse reset between writes -> the bus goes idle the same cycle and all registers read back at reset values.

Source files
------------

// File: rtl/led_pio_sequencer.sv
// Autonomous LED PIO animator: Avalon-MM master issuing single-cycle PIO data writes
// (static/blink/rotate/count) at a programmable rate, configured via a zero-wait slave.
module led_pio_sequencer #(
    parameter int unsigned          LED_WIDTH   = 8,
    parameter int unsigned          DIV_WIDTH   = 24,
    parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 24'd5_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           s_address,
    input  logic                 s_chipselect,
    input  logic                 s_write_n,
    input  logic [31:0]          s_writedata,
    output logic [31:0]          s_readdata,
    output logic [1:0]           m_address,
    output logic                 m_chipselect,
    output logic                 m_write_n,
    output logic [31:0]          m_writedata,
    output logic [LED_WIDTH-1:0] leds_shadow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [2:0]             ctrl_q, ctrl_d;
    logic [LED_WIDTH-1:0]   pattern_q, pattern_d;
    logic [DIV_WIDTH-1:0]   divider_q, divider_d;
    logic [LED_WIDTH-1:0]   shadow_q, shadow_d;
    logic [LED_WIDTH-1:0]   leds_q, leds_d;
    logic [DIV_WIDTH-1:0]   presc_q, presc_d;
    logic [15:0]            wcount_q, wcount_d;
    logic                   pend_q, pend_d;

    logic                   cfg_we;
    logic                   pat_we;
    logic                   enable;
    logic [1:0]             mode;
    logic [DIV_WIDTH-1:0]   d_last;
    logic [LED_WIDTH-1:0]   next_pat;
    logic                   unused_wdata;

    assign cfg_we       = s_chipselect & ~s_write_n;
    assign pat_we       = cfg_we && (s_address == 2'd1);
    assign enable       = ctrl_q[0];
    assign mode         = ctrl_q[2:1];
    assign d_last       = (divider_q == '0) ? '0 : divider_q - DIV_WIDTH'(1);
    assign unused_wdata = ^s_writedata;

    always_comb begin
        next_pat = shadow_q;
        case (mode)
            2'd1:    next_pat = (shadow_q == pattern_q) ? '0 : pattern_q;
            2'd2:    next_pat = {shadow_q[LED_WIDTH-2:0], shadow_q[LED_WIDTH-1]};
            2'd3:    next_pat = shadow_q + LED_WIDTH'(1);
            default: next_pat = shadow_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        pattern_d = pattern_q;
        divider_d = divider_q;
        shadow_d  = shadow_q;
        leds_d    = leds_q;
        presc_d   = presc_q;
        wcount_d  = wcount_q;
        pend_d    = pend_q;

        if (cfg_we) begin
            case (s_address)
                2'd0:    ctrl_d    = s_writedata[2:0];
                2'd1:    pattern_d = s_writedata[LED_WIDTH-1:0];
                2'd2:    divider_d = s_writedata[DIV_WIDTH-1:0];
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                pend_d = 1'b0;
                if (enable) begin
                    shadow_d = pattern_q;
                    presc_d  = '0;
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                wcount_d = wcount_q + 16'd1;
                leds_d   = shadow_q;
                // A PATTERN write here cannot alter the write in flight; restart next RUN cycle.
                if (pat_we)
                    pend_d = 1'b1;
                state_d = enable ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                if (!enable) begin
                    pend_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (pat_we) begin
                    shadow_d = s_writedata[LED_WIDTH-1:0];
                    presc_d  = '0;
                    pend_d   = 1'b0;
                    state_d  = ST_WRITE;
                end else if (pend_q) begin
                    shadow_d = pattern_q;
                    presc_d  = '0;
                    pend_d   = 1'b0;
                    state_d  = ST_WRITE;
                end else if (mode != 2'd0) begin
                    if (presc_q == d_last) begin
                        presc_d  = '0;
                        shadow_d = next_pat;
                        state_d  = ST_WRITE;
                    end else begin
                        presc_d = presc_q + DIV_WIDTH'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= '0;
            pattern_q <= '0;
            divider_q <= DEFAULT_DIV;
            shadow_q  <= '0;
            leds_q    <= '0;
            presc_q   <= '0;
            wcount_q  <= '0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            pattern_q <= pattern_d;
            divider_q <= divider_d;
            shadow_q  <= shadow_d;
            leds_q    <= leds_d;
            presc_q   <= presc_d;
            wcount_q  <= wcount_d;
            pend_q    <= pend_d;
        end
    end

    assign m_address    = '0;
    assign m_chipselect = (state_q == ST_WRITE);
    assign m_write_n    = (state_q != ST_WRITE);
    assign leds_shadow  = leds_q;

    always_comb begin
        m_writedata = '0;
        if (state_q == ST_WRITE)
            m_writedata[LED_WIDTH-1:0] = shadow_q;
    end

    always_comb begin
        s_readdata = '0;
        case (s_address)
            2'd0: s_readdata[2:0]           = ctrl_q;
            2'd1: s_readdata[LED_WIDTH-1:0] = pattern_q;
            2'd2: s_readdata[DIV_WIDTH-1:0] = divider_q;
            default: begin
                s_readdata[15:0]  = wcount_q;
                s_readdata[17:16] = state_q;
            end
        endcase
    end

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Randomised self-checking bench: PIO writes are logged by cycle and compared with a
// transaction-level schedule (first write E+1, then every D+1 cycles, restarts on PATTERN).
module tb_led_pio_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  s_address;
    logic        s_chipselect;
    logic        s_write_n;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic [7:0]  leds_shadow;

    led_pio_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .s_address   (s_address),
        .s_chipselect(s_chipselect),
        .s_write_n   (s_write_n),
        .s_writedata (s_writedata),
        .s_readdata  (s_readdata),
        .m_address   (m_address),
        .m_chipselect(m_chipselect),
        .m_write_n   (m_write_n),
        .m_writedata (m_writedata),
        .leds_shadow (leds_shadow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
        logic [1:0]  addr;
    } wr_t;

    wr_t         log_q[$];
    wr_t         exp_q[$];
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned wc_model = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (!reset && m_chipselect && !m_write_n)
            log_q.push_back('{cyc, m_writedata, m_address});

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] next_val(input int unsigned mode, input logic [7:0] s,
                                            input logic [7:0] pat);
        int unsigned v;
        v = s;
        case (mode)
            1:       v = (s == pat) ? 0 : pat;
            2:       v = ((v * 2) % 256) + (v / 128);
            3:       v = (v + 1) % 256;
            default: v = s;
        endcase
        return v[7:0];
    endfunction

    // Append the writes of one animation run starting at cycle t, up to cycle t_end.
    function automatic void gen(input int unsigned t, input logic [7:0] s, input logic [7:0] pat,
                                input int unsigned d, input int unsigned mode,
                                input int unsigned t_end);
        while (t <= t_end) begin
            exp_q.push_back('{t, {24'h0, s}, 2'b00});
            if (mode == 0) break;
            s = next_val(mode, s, pat);
            t += d + 1;
        end
    endfunction

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d, output int unsigned e);
        s_address    = a;
        s_writedata  = d;
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        @(posedge clk);
        #1;
        e            = cyc;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
        s_address    = a;
        s_chipselect = 1'b1;
        s_write_n    = 1'b1;
        #1;
        d            = s_readdata;
        s_chipselect = 1'b0;
    endtask

    task automatic at_cycle(input int unsigned n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_scn(input logic [7:0] pat, input int unsigned div, input int unsigned mode,
                           input int unsigned run_len, input bit do_restart,
                           input logic [7:0] new_pat, input int unsigned restart_off);
        int unsigned e, t0, d, c, r, x;
        logic [31:0] st0, st1;
        exp_q.delete();
        log_q.delete();
        cfg_write(2'd1, {24'h0, pat}, e);
        cfg_write(2'd2, div, e);
        cfg_write(2'd0, (mode << 1) | 1, e);
        t0 = e + 1;
        d  = (div == 0) ? 1 : div;
        if (do_restart) begin
            c = t0 + restart_off;
            at_cycle(c);
            cfg_write(2'd1, {24'h0, new_pat}, e);
            gen(t0, pat, pat, d, mode, c);
            r = (exp_q[$].cyc == c) ? c + 2 : c + 1;
            at_cycle(r + run_len);
            cfg_write(2'd0, mode << 1, x);
            gen(r, new_pat, new_pat, d, mode, x);
        end else begin
            at_cycle(t0 + run_len);
            cfg_write(2'd0, mode << 1, x);
            gen(t0, pat, pat, d, mode, x);
        end
        repeat (d + 8) @(posedge clk);
        #1;
        check_eq("nwrites", log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check_eq($sformatf("wr%0d_cyc", i), log_q[i].cyc, exp_q[i].cyc);
            check_eq($sformatf("wr%0d_data", i), log_q[i].data, exp_q[i].data);
            check_eq($sformatf("wr%0d_addr", i), {30'h0, log_q[i].addr}, 32'h0);
        end
        wc_model += exp_q.size();
        cfg_read(2'd3, st0);
        repeat (3) @(posedge clk);
        #1;
        cfg_read(2'd3, st1);
        check_eq("status", st0, wc_model % 65536);
        check_eq("status_stable", st1, wc_model % 65536);
        check_eq("leds_last", {24'h0, leds_shadow}, exp_q[$].data);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end of the test sequence");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int unsigned e;
        bit          found;

        reset        = 1'b1;
        s_address    = 2'd0;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
        s_writedata  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        check_eq("rst_cs", {31'h0, m_chipselect}, 32'h0);
        check_eq("rst_wn", {31'h0, m_write_n}, 32'h1);
        check_eq("rst_addr", {30'h0, m_address}, 32'h0);
        check_eq("rst_wdata", m_writedata, 32'h0);
        check_eq("rst_leds", {24'h0, leds_shadow}, 32'h0);
        cfg_read(2'd2, rd);
        check_eq("rst_div", rd, 32'd5_000_000);
        cfg_read(2'd3, rd);
        check_eq("rst_status", rd, 32'h0);

        // static, rotate, count, blink with a PATTERN write landing on a tick
        run_scn(8'hA5, 3, 0, 100, 1'b0, 8'h00, 0);
        run_scn(8'h81, 3, 2, 14, 1'b0, 8'h00, 0);
        if (log_q.size() >= 4) begin
            check_eq("rot_w3", log_q[3].data, 32'h0C);
            check_eq("rot_gap", log_q[1].cyc - log_q[0].cyc, 32'd4);
        end
        run_scn(8'hFE, 0, 3, 6, 1'b0, 8'h00, 0);
        if (log_q.size() >= 4) begin
            check_eq("cnt_w2", log_q[2].data, 32'h00);
            check_eq("cnt_w3", log_q[3].data, 32'h01);
            check_eq("cnt_gap", log_q[1].cyc - log_q[0].cyc, 32'd2);
        end
        run_scn(8'h0F, 5, 1, 8, 1'b1, 8'h3C, 5);
        if (log_q.size() >= 3) begin
            check_eq("blk_w1", log_q[1].data, 32'h3C);
            check_eq("blk_w2", log_q[2].data, 32'h00);
            check_eq("blk_gap", log_q[2].cyc - log_q[1].cyc, 32'd6);
        end

        for (int it = 0; it < 10; it++)
            run_scn(8'($urandom), $urandom_range(0, 5), $urandom_range(0, 3),
                    $urandom_range(3, 40), 1'($urandom_range(0, 1)), 8'($urandom),
                    $urandom_range(0, 20));

        // reset asserted while a PIO write is on the bus
        cfg_write(2'd1, 32'h81, e);
        cfg_write(2'd2, 32'd3, e);
        cfg_write(2'd0, 32'h5, e);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_chipselect && !m_write_n) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("arst_write_seen", {31'h0, found}, 32'h1);
        #1;
        reset = 1'b1;
        #1;
        check_eq("arst_cs", {31'h0, m_chipselect}, 32'h0);
        check_eq("arst_wn", {31'h0, m_write_n}, 32'h1);
        check_eq("arst_wdata", m_writedata, 32'h0);
        cfg_read(2'd0, rd);
        check_eq("arst_ctrl", rd, 32'h0);
        cfg_read(2'd1, rd);
        check_eq("arst_pattern", rd, 32'h0);
        cfg_read(2'd2, rd);
        check_eq("arst_div", rd, 32'd5_000_000);
        cfg_read(2'd3, rd);
        check_eq("arst_status", rd, 32'h0);
        check_eq("arst_leds", {24'h0, leds_shadow}, 32'h0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        wc_model = 0;
        @(posedge clk);
        #1;

        run_scn(8'h3C, 2, 2, 12, 1'b0, 8'h00, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
